serial_subtractor4: RTL
=======================

Name: serial_subtractor4

Overview:
- Bit-serial, multi-cycle subtractor: computes A - B LSB-first through a single borrow stage, one bit per clock.
- Inverse-operation companion to the team's FullAdder4bit.
- Serves as the checking and inverse path: the same bench can feed Sum back and recover an operand.
- Start/busy/done handshake lets a controller issue back-to-back operations.

Parameters:
- WIDTH, 4, operand width in bits; Diff is WIDTH+1 bits; latency = WIDTH cycles.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request pulse; A and B are sampled on the same edge
- A  input  WIDTH  minuend, unsigned
- B  input  WIDTH  subtrahend, unsigned
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  one-cycle pulse; Diff and Borrow are valid from this cycle
- Diff  output  WIDTH+1  A - B as two's complement: {Borrow, diff[WIDTH-1:0]}
- Borrow  output  1  1 iff A < B; equals Diff[WIDTH]

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n); nothing is asynchronous.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, Diff=0, Borrow=0.
  - Internal shift registers, bit counter and borrow flop are cleared.
  - Reset overrides start and aborts any operation in flight, with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge -> latch A into sa and B into sb; bw=0; cnt=0; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT (busy=1), on each edge:
  - d = sa[0]^sb[0]^bw
  - bw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bw)
  - d shifts into the MSB of the result register; sa and sb shift right; cnt <= cnt+1.
  - On the edge where cnt = WIDTH-1: Diff <= {bw_next, result_next}, Borrow <= bw_next, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The next edge goes to IDLE, or to SHIFT if start=1 (back-to-back issue, operands latched as in IDLE).
- Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH (4 for default).
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored; operands and result are unaffected.
- A/B changing after the start edge has no effect, because operands are latched.
- Diff and Borrow hold their last value until the next completion or reset; they do not change during SHIFT.
- Arithmetic wrap: Diff is A - B mod 2^(WIDTH+1), interpreted signed.
  - Range -(2^WIDTH - 1) .. +(2^WIDTH - 1); no overflow is possible.
- No combinational path from any input to any output; all outputs are registered or decoded from state.

Test Plan:
- Reset, then start with A=5, B=5 -> busy high for 4 cycles, then done pulse; Diff=5'b00000, Borrow=0.
- A=15, B=0 -> Diff=5'b01111 (15), Borrow=0. Then A=0, B=15 -> Diff=5'b10001 (-15), Borrow=1.
- A=5, B=10 -> Diff=5'b11011 (-5), Borrow=1; done asserted exactly 4 edges after the start edge.
- Start A=9, B=3; pulse start with A=1, B=2 while busy -> Diff=6 only, a single done pulse, second request dropped.
- Back-to-back: start held during the DONE cycle with A=15, B=15 -> first result visible at done, SHIFT re-entered immediately; second done gives Diff=0.
- rst_n low for one edge mid-SHIFT (after 2 bits) -> busy=0, Diff=0, no done pulse. A new start with A=7, B=2 then gives Diff=5.

Source files
------------

// File: rtl/serial_subtractor4.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor4
// Brief  : Bit-serial LSB-first subtractor (A - B), one borrow stage, start/busy/done handshake.
// Rev    : 1.0  initial release
// ============================================================================
module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Diff,
    output logic             Borrow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_bw;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_diff;
    logic             r_borrow;

    logic             w_load;
    logic             w_last;
    logic             w_d;
    logic             w_bw_next;
    logic [WIDTH-1:0] w_res_next;

    // Operands may be (re)loaded from IDLE or straight out of DONE for back-to-back issue.
    assign w_load     = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_cnt == c_last);
    assign w_d        = r_sa[0] ^ r_sb[0] ^ r_bw;
    assign w_bw_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_bw);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_load) begin
            r_sa  <= A;
            r_sb  <= B;
            r_res <= '0;
            r_bw  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_res <= w_res_next;
            r_bw  <= w_bw_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff   <= {w_bw_next, w_res_next};
                r_borrow <= w_bw_next;
            end
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign Diff   = r_diff;
    assign Borrow = r_borrow;

endmodule
`default_nettype wire
